// File: rtl/mux_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux select controller.
package mux_ctrl_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  // One-hot vector with only bit idx set.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/four_to_one_mux.sv
// Plain 4:1 data multiplexer driven by the scheduler's select.
module four_to_one_mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  // Route the selected input to the output.
  always_comb begin
    unique case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester after 'last', wrapping around.
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] pick,
  output logic             any
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    pick = last;
    any  = |req;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end

endmodule

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin owner scheduler for a shared 4:1 mux channel. A turnaround cycle with no
// grant precedes every select change; a time slice bounds ownership under contention.
module mux_rr_sel_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int unsigned SLICE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy
);

  localparam int unsigned      CNT_W   = $clog2(SLICE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLICE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_last;
  logic [SEL_W-1:0] pick;
  logic             pick_any;
  logic             owner_req;
  logic             others;
  logic             expired;

  // When leaving GRANT the current owner becomes 'last' on the same edge, so the
  // picker must already search from sel rather than from the stale last register.
  assign pick_last = (state_q == ST_GRANT) ? sel_q : last_q;

  rr_pick4 u_pick (
    .req  (req),
    .last (pick_last),
    .pick (pick),
    .any  (pick_any)
  );

  assign owner_req = req[sel_q];
  assign others    = |(req & ~onehot(sel_q));
  assign expired   = (cnt_q == CNT_MAX);

  // Next-state, select, grant and slice counter decisions.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          state_d = ST_LOAD;
          sel_d   = pick;
        end
      end

      ST_LOAD: begin
        if (owner_req) begin
          state_d = ST_GRANT;
          grant_d = onehot(sel_q);
          cnt_d   = '0;
        end else begin
          // Requester withdrew during turnaround: give up without touching last.
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          // Release takes precedence over a coincident slice expiry.
          last_d  = sel_q;
          grant_d = '0;
          cnt_d   = '0;
          if (pick_any) begin
            state_d = ST_LOAD;
            sel_d   = pick;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (expired && others) begin
          last_d  = sel_q;
          grant_d = '0;
          cnt_d   = '0;
          state_d = ST_LOAD;
          sel_d   = pick;
        end else if (expired) begin
          // Nobody else waiting: extend the owner with a fresh slice.
          cnt_d = '0;
        end else begin
          // Never passes CNT_MAX since expiry always clears or exits above.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// Directed bench for mux_rr_sel_ctrl driving a four_to_one_mux with toggling data.
`timescale 1ns/1ps
module tb_mux_rr_sel_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic [5:0] tick  = '0;
  logic [7:0] d0, d1, d2, d3, mux_out;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  // Data inputs change every cycle so a wrong select shows up on the mux output.
  always @(posedge clk) tick <= tick + 6'd1;
  assign d0 = {tick, 2'd0};
  assign d1 = {tick, 2'd1} ^ 8'hA5;
  assign d2 = {tick, 2'd2} ^ 8'h3C;
  assign d3 = {tick, 2'd3} ^ 8'hC3;

  mux_rr_sel_ctrl #(.SLICE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .sel   (sel),
    .grant (grant),
    .busy  (busy)
  );

  four_to_one_mux #(.WIDTH(8)) u_mux (
    .in0 (d0),
    .in1 (d1),
    .in2 (d2),
    .in3 (d3),
    .sel (sel),
    .out (mux_out)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  task automatic push_exp(input logic [3:0] eg, input logic [1:0] es, input logic eb);
    exp_t e;
    e.g = eg;
    e.s = es;
    e.b = eb;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the current DUT outputs.
  task automatic compare(input string tag);
    exp_t       e;
    logic [7:0] dexp;
    e = sb.pop_front();
    chk($sformatf("%s grant", tag), 32'(grant), 32'(e.g));
    chk($sformatf("%s sel", tag), 32'(sel), 32'(e.s));
    chk($sformatf("%s busy", tag), 32'(busy), 32'(e.b));
    if (e.g != 4'b0000) begin
      case (e.g)
        4'b0001: dexp = d0;
        4'b0010: dexp = d1;
        4'b0100: dexp = d2;
        default: dexp = d3;
      endcase
      chk($sformatf("%s mux", tag), 32'(mux_out), 32'(dexp));
    end
  endtask

  // Apply req for one edge, then check the expected registered outputs.
  task automatic cyc(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                     input logic eb, input string tag);
    req = r;
    push_exp(eg, es, eb);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Assert reset between edges, check it acts at once, hold over an edge, release.
  task automatic do_reset(input logic [3:0] r, input string tag);
    req = r;
    #2;
    rst_n = 1'b0;
    push_exp(4'b0000, 2'd0, 1'b0);
    #1;
    compare(tag);
    @(posedge clk);
    #1;
    push_exp(4'b0000, 2'd0, 1'b0);
    compare($sformatf("%s held", tag));
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with all requests high
    do_reset(4'b1111, "reset");

    // Single request latency
    cyc(4'b0100, 4'b0000, 2'd2, 1'b1, "single load");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "single grant");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "single release");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "single idle");

    // Rotation under full contention: 4-cycle slices with turnaround gaps
    do_reset(4'b1111, "reset2");
    for (int g = 0; g < 5; g++) begin
      cyc(4'b1111, 4'b0000, 2'(g % 4), 1'b1, $sformatf("rot%0d turn", g));
      for (int k = 0; k < 4; k++)
        cyc(4'b1111, 4'b0001 << (g % 4), 2'(g % 4), 1'b1, $sformatf("rot%0d c%0d", g, k));
    end

    // No-contention extension: owner 1 keeps the channel for 20 cycles
    cyc(4'b0010, 4'b0000, 2'd1, 1'b1, "ext load");
    for (int k = 0; k < 20; k++)
      cyc(4'b0010, 4'b0010, 2'd1, 1'b1, $sformatf("ext c%0d", k));

    // Early release by owner 0 while requester 3 waits
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "ext release");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "idle hold");
    cyc(4'b0001, 4'b0000, 2'd0, 1'b1, "er load");
    cyc(4'b0001, 4'b0001, 2'd0, 1'b1, "er c0");
    cyc(4'b1001, 4'b0001, 2'd0, 1'b1, "er c1");
    cyc(4'b1000, 4'b0000, 2'd3, 1'b1, "er turn");
    cyc(4'b1000, 4'b1000, 2'd3, 1'b1, "er grant3");

    // Requester 1 withdraws during its turnaround; last stays at 3
    cyc(4'b0010, 4'b0000, 2'd1, 1'b1, "abort load");
    cyc(4'b0000, 4'b0000, 2'd1, 1'b0, "abort idle");
    cyc(4'b1111, 4'b0000, 2'd0, 1'b1, "last kept load");
    cyc(4'b1111, 4'b0001, 2'd0, 1'b1, "last kept grant");

    // Make last=2 with requester 2 owning the channel, then reset mid-grant
    cyc(4'b0100, 4'b0000, 2'd2, 1'b1, "pre load a");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "pre grant a");
    cyc(4'b0000, 4'b0000, 2'd2, 1'b0, "pre release");
    cyc(4'b0100, 4'b0000, 2'd2, 1'b1, "pre load b");
    cyc(4'b0100, 4'b0100, 2'd2, 1'b1, "pre grant b");
    do_reset(4'b1100, "mid reset");
    cyc(4'b1100, 4'b0000, 2'd2, 1'b1, "post reset load");
    cyc(4'b1100, 4'b0100, 2'd2, 1'b1, "post reset grant");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
